// File: rtl/bakraid_pkg.sv
// Shared definitions for the Bakraid 68k-side sound command port.
// Holds the register map offsets and the bus FSM state encoding.
package bakraid_pkg;

  localparam logic [2:0] OFS_LATCH1 = 3'd0;
  localparam logic [2:0] OFS_LATCH2 = 3'd1;
  localparam logic [2:0] OFS_TRIG   = 3'd2;
  localparam logic [2:0] OFS_REPLY  = 3'd3;
  localparam logic [2:0] OFS_STAT   = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    STALL,
    DONE
  } state_t;

  function automatic logic is_trigger(input logic rnw, input logic [2:0] a);
    return !rnw && (a == OFS_TRIG);
  endfunction

  function automatic logic is_reply_read(input logic rnw, input logic [2:0] a);
    return rnw && (a == OFS_REPLY);
  endfunction

endpackage

// File: rtl/bakraid_snd_cmd_if.sv
// 68k bus window into the sound command port.
// Handshake: the master raises M68_CS with A/RNW/DIN stable and holds it until M68_DTACKn
// goes low; it then drops M68_CS, and the slave returns M68_DTACKn high on the next cycle.
interface bakraid_snd_cmd_if;
  logic        M68_CS;
  logic        M68_RNW;
  logic [2:0]  M68_A;
  logic [7:0]  M68_DIN;
  logic [15:0] M68_DOUT;
  logic        M68_DTACKn;

  modport master (
    output M68_CS,
    output M68_RNW,
    output M68_A,
    output M68_DIN,
    input  M68_DOUT,
    input  M68_DTACKn
  );

  modport slave (
    input  M68_CS,
    input  M68_RNW,
    input  M68_A,
    input  M68_DIN,
    output M68_DOUT,
    output M68_DTACKn
  );
endinterface

// File: rtl/bakraid_pulse_gen.sv
// Reloadable down-counter pulse generator: pulse is high while the count is non-zero.
// A load during an active pulse restarts the count, stretching the pulse with no gap.
module bakraid_pulse_gen #(
  parameter int W   = 8,
  parameter int LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic pulse
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(LEN);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign pulse = (cnt != '0);

endmodule

// File: rtl/bakraid_snd_cmd.sv
// 68k-side sound command port: command latches, trigger strobe with WAIT stall and
// timeout, Z80 NMI pulse, and reply readback with per-byte ACK tracking.
module bakraid_snd_cmd
  import bakraid_pkg::*;
#(
  parameter int NMI_W   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic        CLK,
  input  logic        RESET,
  bakraid_snd_cmd_if.slave m68,
  output logic [7:0]  SOUNDLATCH,
  output logic [7:0]  SOUNDLATCH2,
  output logic        NMI,
  output logic        SND_CS,
  input  logic        SND_WAIT,
  input  logic [7:0]  SOUNDLATCH3,
  input  logic [7:0]  SOUNDLATCH4,
  input  logic [1:0]  ACK_IN,
  output logic [1:0]  ACK_OUT,
  output state_t      STATE
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state;
  logic          cs_q;
  logic [2:0]    a_q;
  logic          rnw_q;
  logic [7:0]    din_q;
  logic [TW-1:0] stall_cnt;
  logic [1:0]    ack_q;
  logic          ack_clr;

  assign STATE   = state;
  assign ack_clr = (state == ACCESS) && is_reply_read(rnw_q, a_q);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= IDLE;
      cs_q           <= 1'b0;
      a_q            <= '0;
      rnw_q          <= 1'b0;
      din_q          <= '0;
      stall_cnt      <= '0;
      SOUNDLATCH     <= '0;
      SOUNDLATCH2    <= '0;
      SND_CS         <= 1'b0;
      m68.M68_DOUT   <= '0;
      m68.M68_DTACKn <= 1'b1;
    end else begin
      cs_q   <= m68.M68_CS;
      SND_CS <= 1'b0;
      case (state)
        IDLE: begin
          if (m68.M68_CS && !cs_q) begin
            a_q   <= m68.M68_A;
            rnw_q <= m68.M68_RNW;
            din_q <= m68.M68_DIN;
            state <= ACCESS;
          end
        end

        ACCESS: begin
          if (rnw_q) begin
            case (a_q)
              OFS_REPLY: m68.M68_DOUT <= {SOUNDLATCH4, SOUNDLATCH3};
              OFS_STAT:  m68.M68_DOUT <= {14'b0, ACK_OUT};
              default:   m68.M68_DOUT <= '0;
            endcase
          end else if (a_q == OFS_LATCH1) begin
            SOUNDLATCH <= din_q;
          end else if (a_q == OFS_LATCH2) begin
            SOUNDLATCH2 <= din_q;
          end
          // The register action above stands even when the 68k aborts here.
          if (!m68.M68_CS) begin
            state <= IDLE;
          end else if (is_trigger(rnw_q, a_q)) begin
            if (SND_WAIT) begin
              stall_cnt <= '0;
              state     <= STALL;
            end else begin
              SND_CS <= 1'b1;
              state  <= DONE;
            end
          end else begin
            state <= DONE;
          end
        end

        STALL: begin
          if (!m68.M68_CS) begin
            state <= IDLE;
          end else if (!SND_WAIT || (stall_cnt == TW'(TIMEOUT - 1))) begin
            SND_CS <= 1'b1;
            state  <= DONE;
          end else begin
            stall_cnt <= stall_cnt + TW'(1);
          end
        end

        DONE: begin
          if (m68.M68_CS) begin
            m68.M68_DTACKn <= 1'b0;
          end else begin
            m68.M68_DTACKn <= 1'b1;
            state          <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // A fresh reply edge outranks the read-clear so no reply is ever dropped.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ack_q   <= '0;
      ACK_OUT <= '0;
    end else begin
      ack_q   <= ACK_IN;
      ACK_OUT <= (ACK_OUT & ~{2{ack_clr}}) | (ACK_IN & ~ack_q);
    end
  end

  bakraid_pulse_gen #(
    .W   (8),
    .LEN (NMI_W)
  ) u_nmi (
    .clk   (CLK),
    .rst   (RESET),
    .load  (SND_CS),
    .pulse (NMI)
  );

endmodule

// File: tb/tb_bakraid_snd_cmd.sv
// Bench for bakraid_snd_cmd: directed scenarios followed by randomized bus traffic,
// checked against a register-map model, interval-based NMI model and latency rules.
module tb_bakraid_snd_cmd;
  import bakraid_pkg::*;

  localparam int NMI_W   = 8;
  localparam int TIMEOUT = 4096;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bakraid_snd_cmd_if m68();
  logic [7:0] sl1, sl2, sl3, sl4;
  logic       nmi, snd_cs, snd_wait;
  logic [1:0] ack_in, ack_out;
  state_t     state;

  bakraid_snd_cmd #(.NMI_W(NMI_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK         (clk),
    .RESET       (rst),
    .m68         (m68.slave),
    .SOUNDLATCH  (sl1),
    .SOUNDLATCH2 (sl2),
    .NMI         (nmi),
    .SND_CS      (snd_cs),
    .SND_WAIT    (snd_wait),
    .SOUNDLATCH3 (sl3),
    .SOUNDLATCH4 (sl4),
    .ACK_IN      (ack_in),
    .ACK_OUT     (ack_out),
    .STATE       (state)
  );

  // ---------------- scoreboard / model state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  m_l1, m_l2;
  logic [1:0]  m_pend;
  int          trig_q[$];
  int          cyc = 0;
  bit          mon_en = 0;
  bit          nmi_exp;
  int          nmi_hi = 0;

  logic [15:0] rd, exp_rd;
  int          lat, csl, csn, exp_lat, exp_cs, rel;
  logic        rnw_r, trig_r, stall_r;
  logic [2:0]  a_r;
  logic [7:0]  d_r;
  logic [1:0]  new_ack;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // NMI is high exactly in the cycles covered by some trigger's NMI_W window.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (mon_en) begin
      nmi_exp = 1'b0;
      foreach (trig_q[i]) if (trig_q[i] < cyc && cyc <= trig_q[i] + NMI_W) nmi_exp = 1'b1;
      check("nmi", 16'(nmi), 16'(nmi_exp));
      if (nmi) nmi_hi++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ack_in = '0;
    trig_q.delete();
    m_l1 = '0; m_l2 = '0; m_pend = '0;
    @(posedge clk); #1;
    check("rst_latch1", 16'(sl1), 16'h0);
    check("rst_latch2", 16'(sl2), 16'h0);
    check("rst_nmi", 16'(nmi), 16'h0);
    check("rst_snd_cs", 16'(snd_cs), 16'h0);
    check("rst_ack_out", 16'(ack_out), 16'h0);
    check("rst_dout", m68.M68_DOUT, 16'h0);
    check("rst_dtack", 16'(m68.M68_DTACKn), 16'h1);
    check("rst_state", 16'(state), 16'(IDLE));
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full 68k bus cycle. Latencies are counted in rising edges from the one that samples CS.
  task automatic bus(input logic rnw, input logic [2:0] a, input logic [7:0] d,
                     input int exp_cs_lat, input int release_at, input int ack_lat,
                     input logic [1:0] ack_set, input int gap,
                     output logic [15:0] rdata, output int l, output int cs_l, output int cs_n);
    @(negedge clk);
    m68.M68_A = a; m68.M68_RNW = rnw; m68.M68_DIN = d; m68.M68_CS = 1'b1;
    l = 0; cs_l = 0; cs_n = 0;
    while (1) begin
      @(posedge clk); #1;
      l++;
      if (l == exp_cs_lat) trig_q.push_back(cyc);
      if (snd_cs) begin
        cs_n++;
        if (cs_l == 0) cs_l = l;
      end
      if (release_at >= 0 && l == 2 + release_at) snd_wait = 1'b0;
      if (l == ack_lat) ack_in = ack_in | ack_set;
      if (!m68.M68_DTACKn) break;
      if (l > TIMEOUT + 20) begin
        checks++; errors++;
        $display("FAIL dtack_wait: no DTACK after %0d cycles, required by %0d", l, TIMEOUT + 3);
        break;
      end
    end
    rdata = m68.M68_DOUT;
    m68.M68_CS = 1'b0;
    @(posedge clk); #1;
    if (snd_cs) cs_n++;
    check("dtack_release", 16'(m68.M68_DTACKn), 16'h1);
    check("state_idle", 16'(state), 16'(IDLE));
    repeat (gap) @(posedge clk);
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_latch1"}, 16'(sl1), 16'(m_l1));
    check({tag, "_latch2"}, 16'(sl2), 16'(m_l2));
    check({tag, "_ack_out"}, 16'(ack_out), 16'(m_pend));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m68.M68_CS = 1'b0; m68.M68_RNW = 1'b1; m68.M68_A = '0; m68.M68_DIN = '0;
    snd_wait = 1'b0; sl3 = '0; sl4 = '0; ack_in = '0;
    repeat (2) @(posedge clk);
    do_reset();
    mon_en = 1;

    // Latch writes: plain cycles complete two edges after CS is sampled.
    m_l1 = 8'h5A;
    bus(1'b0, OFS_LATCH1, 8'h5A, 0, -1, 0, 2'b00, 0, rd, lat, csl, csn);
    check("w0_lat", 16'(lat), 16'd3);
    m_l2 = 8'hA5;
    bus(1'b0, OFS_LATCH2, 8'hA5, 0, -1, 0, 2'b00, 0, rd, lat, csl, csn);
    check("w1_lat", 16'(lat), 16'd3);
    check("w1_cs_count", 16'(csn), 16'd0);
    check_regs("latches");

    // Two triggers five cycles apart: NMI_W + 5 high cycles in total.
    nmi_hi = 0;
    bus(1'b0, OFS_TRIG, 8'h00, 2, -1, 0, 2'b00, 1, rd, lat, csl, csn);
    check("trig1_cs_at", 16'(csl), 16'd2);
    check("trig1_cs_count", 16'(csn), 16'd1);
    bus(1'b0, OFS_TRIG, 8'h00, 2, -1, 0, 2'b00, 0, rd, lat, csl, csn);
    check("trig2_cs_at", 16'(csl), 16'd2);
    repeat (20) @(posedge clk);
    check("nmi_stretch_len", 16'(nmi_hi), 16'(NMI_W + 5));

    // Stall released after 100 cycles.
    snd_wait = 1'b1;
    bus(1'b0, OFS_TRIG, 8'h00, 103, 100, 0, 2'b00, 0, rd, lat, csl, csn);
    check("stall_cs_at", 16'(csl), 16'd103);
    check("stall_cs_count", 16'(csn), 16'd1);
    check("stall_lat", 16'(lat), 16'd104);

    // SND_WAIT stuck: forced completion after TIMEOUT stall cycles.
    snd_wait = 1'b1;
    bus(1'b0, OFS_TRIG, 8'h00, TIMEOUT + 2, -1, 0, 2'b00, 0, rd, lat, csl, csn);
    snd_wait = 1'b0;
    check("timeout_cs_at", 16'(csl), 16'(TIMEOUT + 2));
    check("timeout_lat", 16'(lat), 16'(TIMEOUT + 3));

    // Reply path.
    sl3 = 8'h33; sl4 = 8'h44;
    @(negedge clk); ack_in = 2'b01;
    @(negedge clk); ack_in = 2'b00;
    m_pend = m_pend | 2'b01;
    bus(1'b1, OFS_STAT, 8'h00, 0, -1, 0, 2'b00, 0, rd, lat, csl, csn);
    check("stat_read", rd, 16'h0001);
    bus(1'b1, OFS_REPLY, 8'h00, 0, -1, 0, 2'b00, 0, rd, lat, csl, csn);
    m_pend = 2'b00;
    check("reply_read", rd, 16'h4433);
    check_regs("after_reply");

    // ACK_IN[1] rises in the ACCESS cycle of a reply read: the set survives the clear.
    bus(1'b1, OFS_REPLY, 8'h00, 0, -1, 1, 2'b10, 0, rd, lat, csl, csn);
    m_pend = 2'b10;
    check("reply_read2", rd, 16'h4433);
    check_regs("ack_race");
    ack_in = 2'b00;

    // CS dropped mid-stall: trigger is discarded.
    snd_wait = 1'b1;
    csn = 0;
    @(negedge clk);
    m68.M68_A = OFS_TRIG; m68.M68_RNW = 1'b0; m68.M68_DIN = 8'h00; m68.M68_CS = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (snd_cs) csn++;
    end
    check("abort_in_stall", 16'(state), 16'(STALL));
    m68.M68_CS = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (snd_cs) csn++;
    end
    snd_wait = 1'b0;
    check("abort_cs_count", 16'(csn), 16'd0);
    check("abort_state", 16'(state), 16'(IDLE));
    check("abort_dtack", 16'(m68.M68_DTACKn), 16'h1);

    // Reset in the middle of an NMI pulse.
    bus(1'b0, OFS_LATCH1, 8'hC3, 0, -1, 0, 2'b00, 0, rd, lat, csl, csn);
    bus(1'b0, OFS_TRIG, 8'h00, 2, -1, 0, 2'b00, 0, rd, lat, csl, csn);
    do_reset();

    // Randomized traffic against the register-map model.
    for (int n = 0; n < 80; n++) begin
      rnw_r = 1'($urandom_range(0, 1));
      a_r   = 3'($urandom_range(0, 7));
      d_r   = 8'($urandom);
      sl3   = 8'($urandom);
      sl4   = 8'($urandom);
      new_ack = 2'($urandom_range(0, 3));
      m_pend  = m_pend | (new_ack & ~ack_in);
      ack_in  = new_ack;
      trig_r  = !rnw_r && (a_r == OFS_TRIG);
      stall_r = trig_r && ($urandom_range(0, 1) == 1);
      rel     = stall_r ? int'($urandom_range(0, 30)) : -1;
      snd_wait = trig_r ? stall_r : 1'($urandom_range(0, 1));
      exp_cs  = !trig_r ? 0 : (stall_r ? 3 + rel : 2);
      exp_lat = stall_r ? 4 + rel : 3;
      if (rnw_r) begin
        exp_rd = (a_r == OFS_REPLY) ? {sl4, sl3} :
                 (a_r == OFS_STAT)  ? {14'b0, m_pend} : 16'h0000;
        exp_q.push_back(exp_rd);
        if (a_r == OFS_REPLY) m_pend = 2'b00;
      end else if (a_r == OFS_LATCH1) begin
        m_l1 = d_r;
      end else if (a_r == OFS_LATCH2) begin
        m_l2 = d_r;
      end
      bus(rnw_r, a_r, d_r, exp_cs, rel, 0, 2'b00, int'($urandom_range(0, 2)), rd, lat, csl, csn);
      snd_wait = 1'b0;
      check("rnd_lat", 16'(lat), 16'(exp_lat));
      check("rnd_cs_at", 16'(csl), 16'(exp_cs));
      check("rnd_cs_count", 16'(csn), 16'(trig_r ? 1 : 0));
      check_regs("rnd");
      if (rnw_r) check("rnd_read", rd, exp_q.pop_front());
    end
    repeat (20) @(posedge clk);
    check("exp_q_drained", 16'(exp_q.size()), 16'd0);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
